// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped reload timer.
package timer_pkg;

   // Word index inside the 16-byte register window (addr[3:2]).
   typedef enum logic [1:0] {
      IDX_TH   = 2'd0,
      IDX_TL   = 2'd1,
      IDX_TCON = 2'd2,
      IDX_OVF  = 2'd3
   } reg_idx_e;

   // TCON bit positions.
   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h4000_0000;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Divides clk by PRESCALE while enabled; tick marks the wrap of the divider.
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt_q, cnt_d;

   // Tick is combinational so the timer registers see it on the wrap edge.
   assign tick = en && (cnt_q == LAST);

   // Next divider value: clear beats count, count only while enabled.
   always_comb begin
      // NOTE: default assigned first so no path leaves cnt_d unassigned (no latch).
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tick ? '0 : cnt_q + 16'd1;
      end
   end

   // Divider state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
         cnt_q <= cnt_d;
      end
   end

endmodule : timer_prescaler

// File: rtl/timer_peripheral.sv
// 32-bit reload timer with TH/TL/TCON/OVF registers on the data-memory bus.
module timer_peripheral
   import timer_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        interrupt
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [7:0]  ovf_q, ovf_d;

   logic     hit, we, tick, ovf_evt;
   reg_idx_e idx;

   assign hit     = (addr[31:4] == ADDR_BASE[31:4]);
   assign we      = Write && hit;
   assign idx     = reg_idx_e'(addr[3:2]);
   assign ovf_evt = tick && (tl_q == 32'hFFFF_FFFF);

   timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (tcon_q[TCON_EN]),
      .clr   (we && (idx == IDX_TCON)),
      .tick  (tick)
   );

   // Register next-state: bus writes override timer updates on the same edge.
   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      ovf_d  = ovf_q;

      // Any TH/TL write suppresses that cycle's TL increment or reload.
      if (tick && !(we && (idx == IDX_TH || idx == IDX_TL))) begin
         tl_d = ovf_evt ? th_q : tl_q + 32'd1;
      end
      if (ovf_evt) begin
         ovf_d = ovf_q + 8'd1;
         if (tcon_q[TCON_IE]) tcon_d[TCON_IS] = 1'b1;
      end

      if (we) begin
         unique case (idx)
            IDX_TH:   th_d   = wdata;
            IDX_TL:   tl_d   = wdata;
            IDX_TCON: tcon_d = wdata[2:0];
            IDX_OVF:  ;  // read-only
         endcase
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
         ovf_q  <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
         ovf_q  <= ovf_d;
      end
   end

   // Combinational read mux; zero when not selected.
   always_comb begin
      rdata = 32'h0;
      if (Read && hit) begin
         unique case (idx)
            IDX_TH:   rdata = th_q;
            IDX_TL:   rdata = tl_q;
            IDX_TCON: rdata = {29'h0, tcon_q};
            IDX_OVF:  rdata = {24'h0, ovf_q};
         endcase
      end
   end

   assign interrupt = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule : timer_peripheral

// File: tb/tb_timer_peripheral.sv
// Directed scoreboard bench for timer_peripheral (PRESCALE=1 and PRESCALE=4 instances).
module tb_timer_peripheral;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_OVF  = 32'h4000_000C;
   localparam logic [31:0] A_OUT  = 32'h4000_0010;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd0, wr0, rd1, wr1;
   logic [31:0] addr, wdata;
   logic [31:0] rdata0, rdata1;
   logic        int0, int1;

   int total = 0;
   int bad   = 0;
   sb_item_t sb[$];

   always #5 clk = ~clk;

   timer_peripheral #(.PRESCALE(1)) dut0 (
      .clk(clk), .reset(reset), .Read(rd0), .Write(wr0),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .interrupt(int0)
   );

   timer_peripheral #(.PRESCALE(4)) dut1 (
      .clk(clk), .reset(reset), .Read(rd1), .Write(wr1),
      .addr(addr), .wdata(wdata), .rdata(rdata1), .interrupt(int1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input bit sel, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      if (sel) wr1 = 1'b1; else wr0 = 1'b1;
      @(posedge clk);
      #1;
      wr0 = 1'b0;
      wr1 = 1'b0;
   endtask

   // Push the expectation, drive the read, then pop and compare the DUT output.
   task automatic expect_read(input bit sel, input logic [31:0] a, input logic [31:0] exp,
                              input string tag);
      sb_item_t it;
      sb.push_back('{tag: tag, exp: exp});
      addr = a;
      if (sel) rd1 = 1'b1; else rd0 = 1'b1;
      #1;
      it = sb.pop_front();
      check(it.tag, sel ? rdata1 : rdata0, it.exp);
      rd0 = 1'b0;
      rd1 = 1'b0;
   endtask

   initial begin
      rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
      addr = 0; wdata = 0;

      // Reset and initial reads.
      reset = 1'b0;
      #12;
      check("int_in_reset", {31'h0, int0}, 32'h0);
      #5 reset = 1'b1;
      expect_read(0, A_TH,   32'h0, "rst_th");
      expect_read(0, A_TL,   32'h0, "rst_tl");
      expect_read(0, A_TCON, 32'h0, "rst_tcon");
      expect_read(0, A_OVF,  32'h0, "rst_ovf");
      expect_read(0, A_OUT,  32'h0, "rst_outside");
      check("rst_int", {31'h0, int0}, 32'h0);

      // Read-only / reserved bits, Read gating and read-during-write.
      bus_write(1, A_OVF, 32'h55);
      expect_read(1, A_OVF, 32'h0, "ovf_write_ignored");
      bus_write(1, A_TCON, 32'hFFFF_FFF8);
      expect_read(1, A_TCON, 32'h0, "tcon_reserved");
      bus_write(0, A_TH, 32'h11);
      addr = A_TH;
      #1 check("no_read_strobe", rdata0, 32'h0);
      @(negedge clk);
      rd0 = 1; wr0 = 1; addr = A_TH; wdata = 32'hFFFF_FFFC;
      #1 check("rw_prewrite", rdata0, 32'h11);
      @(posedge clk);
      #1 wr0 = 0;
      check("rw_postwrite", rdata0, 32'hFFFF_FFFC);
      rd0 = 0;

      // Prescale by 4: 40 edges after enabling give 10 increments.
      bus_write(1, A_TCON, 32'h1);
      repeat (39) @(posedge clk);
      #1 expect_read(1, A_TL, 32'd9, "presc_39");
      @(posedge clk);
      #1 expect_read(1, A_TL, 32'd10, "presc_40");
      expect_read(1, A_TCON, 32'h1, "presc_is0");
      check("presc_int", {31'h0, int1}, 32'h0);

      // Count and reload.
      bus_write(0, A_TL, 32'hFFFF_FFFE);
      bus_write(0, A_TCON, 32'h3);
      expect_read(0, A_TL, 32'hFFFF_FFFE, "cnt_start");
      @(posedge clk);
      #1 check("cnt_int_pre", {31'h0, int0}, 32'h0);
      expect_read(0, A_TL, 32'hFFFF_FFFF, "cnt_ffff");
      @(posedge clk);
      #1 check("cnt_int_ovf", {31'h0, int0}, 32'h1);
      expect_read(0, A_TL,   32'hFFFF_FFFC, "cnt_reload");
      expect_read(0, A_OVF,  32'h1,         "cnt_ovf1");
      expect_read(0, A_TCON, 32'h7,         "cnt_is1");

      // Interrupt clear and re-assert on the next overflow.
      bus_write(0, A_TCON, 32'h3);
      check("clr_int", {31'h0, int0}, 32'h0);
      expect_read(0, A_TCON, 32'h3, "clr_tcon");
      repeat (2) @(posedge clk);
      #1 check("clr_int_hold", {31'h0, int0}, 32'h0);
      expect_read(0, A_TL, 32'hFFFF_FFFF, "clr_tl_ffff");
      @(posedge clk);
      #1 check("reint", {31'h0, int0}, 32'h1);
      expect_read(0, A_OVF, 32'h2, "reint_ovf2");

      // Collision: TL write on the overflow edge.
      bus_write(0, A_TCON, 32'h0);
      bus_write(0, A_TH, 32'hA5A5);
      bus_write(0, A_TL, 32'hFFFF_FFFF);
      bus_write(0, A_TCON, 32'h1);
      bus_write(0, A_TL, 32'h5);
      expect_read(0, A_TL,  32'h5,    "col_tl_wins");
      expect_read(0, A_OVF, 32'h3,    "col_ovf_counts");
      expect_read(0, A_TH,  32'hA5A5, "col_th_kept");
      @(posedge clk);
      #1 expect_read(0, A_TL, 32'h6, "col_resume");

      // Collision: TCON write on the overflow edge clears IS.
      bus_write(0, A_TCON, 32'h0);
      bus_write(0, A_TL, 32'hFFFF_FFFF);
      bus_write(0, A_TCON, 32'h3);
      bus_write(0, A_TCON, 32'h1);
      expect_read(0, A_TCON, 32'h1,    "col2_tcon");
      check("col2_int", {31'h0, int0}, 32'h0);
      expect_read(0, A_OVF,  32'h4,    "col2_ovf");
      expect_read(0, A_TL,   32'hA5A5, "col2_reload");
      @(posedge clk);
      #1 check("col2_int_next", {31'h0, int0}, 32'h0);

      // Asynchronous reset between edges.
      bus_write(0, A_TCON, 32'h0);
      bus_write(0, A_TH, 32'd100);
      bus_write(0, A_TL, 32'hFFFF_FFFF);
      bus_write(0, A_TCON, 32'h3);
      @(posedge clk);
      #1 check("ar_int_before", {31'h0, int0}, 32'h1);
      expect_read(0, A_TL, 32'd100, "ar_tl_before");
      #2 reset = 1'b0;
      #1 check("ar_int_now", {31'h0, int0}, 32'h0);
      expect_read(0, A_TL,  32'h0, "ar_tl_now");
      expect_read(0, A_OVF, 32'h0, "ar_ovf_now");
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 expect_read(0, A_TL, 32'h0, "ar_tl_idle");
      bus_write(0, A_TCON, 32'h1);
      repeat (2) @(posedge clk);
      #1 expect_read(0, A_TL, 32'd2, "ar_tl_resume");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_timer_peripheral
